// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised counter family.
package counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = unsigned'(i) + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one tick every PRESCALE enabled clocks.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt;

    // With PRESCALE=1, pcnt stays at 0 and tick follows en directly.
    assign tick = en && (pcnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + PW'(1);
        end
    end

endmodule

// File: rtl/param_counter.sv
// Up/down counter with programmable top, prescaled enable, load, wrap/saturate,
// terminal-count pulse and sticky overflow.
module param_counter
    import counter_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  MAX_VAL   = {WIDTH{1'b1}},
    parameter int unsigned       PRESCALE  = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] value,
    output logic             tc,
    output logic             ovf
);

    logic             tick;
    logic             step_c;
    logic             boundary_c;
    logic [WIDTH-1:0] load_clamped_c;
    logic [WIDTH-1:0] value_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

    // A load restarts the prescale period.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    assign load_clamped_c = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    assign step_c         = tick && !load;

    // Next value; a blocked or wrapping step is a boundary step.
    always_comb begin
        value_nxt  = value;
        boundary_c = 1'b0;
        if (load) begin
            value_nxt = load_clamped_c;
        end else if (step_c) begin
            case (up_dn)
                DIR_UP: begin
                    if (value >= MAX_VAL) begin
                        boundary_c = 1'b1;
                        if (sat_mode == MODE_WRAP) begin
                            value_nxt = '0;
                        end
                    end else begin
                        value_nxt = value + WIDTH'(1);
                    end
                end
                DIR_DOWN: begin
                    if (value == '0) begin
                        boundary_c = 1'b1;
                        if (sat_mode != MODE_SAT) begin
                            value_nxt = MAX_VAL;
                        end
                    end else begin
                        value_nxt = value - WIDTH'(1);
                    end
                end
                default: begin
                    value_nxt = value;
                end
            endcase
        end
        tc_nxt  = boundary_c;
        ovf_nxt = boundary_c | (ovf & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= RESET_VAL;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            value <= value_nxt;
            tc    <= tc_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: stimulus queues expected post-edge state,
// monitors pop and compare one entry per clock.
module tb_param_counter;

    typedef struct {
        logic [7:0] value;
        logic       tc;
        logic       ovf;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: PRESCALE=1
    logic       a_reset = 1'b1, a_en = 1'b0, a_up = 1'b1, a_sat = 1'b0;
    logic       a_load = 1'b0, a_clr = 1'b0;
    logic [7:0] a_lv = 8'd0;
    logic [7:0] a_value;
    logic       a_tc, a_ovf;

    // Instance B: PRESCALE=4
    logic       b_reset = 1'b1, b_en = 1'b0;
    logic [7:0] b_value;
    logic       b_tc, b_ovf;

    param_counter #(.WIDTH(8), .MAX_VAL(8'd9), .PRESCALE(1), .RESET_VAL(8'd0)) dut_a (
        .clk(clk), .reset(a_reset), .en(a_en), .up_dn(a_up), .sat_mode(a_sat),
        .load(a_load), .load_val(a_lv), .clr_ovf(a_clr),
        .value(a_value), .tc(a_tc), .ovf(a_ovf)
    );

    param_counter #(.WIDTH(8), .MAX_VAL(8'd9), .PRESCALE(4), .RESET_VAL(8'd0)) dut_b (
        .clk(clk), .reset(b_reset), .en(b_en), .up_dn(1'b1), .sat_mode(1'b0),
        .load(1'b0), .load_val(8'd0), .clr_ovf(1'b0),
        .value(b_value), .tc(b_tc), .ovf(b_ovf)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    always @(a_value) $display("t=%0t a.value=%0d", $time, a_value);
    always @(b_value) $display("t=%0t b.value=%0d", $time, b_value);

    task automatic compare(input string dut, input exp_t e,
                           input logic [7:0] v, input logic t, input logic o);
        checks++;
        if (v !== e.value || t !== e.tc || o !== e.ovf) begin
            errors++;
            $display("FAIL %s.%s @%0t: got value=%0d tc=%0b ovf=%0b, expected value=%0d tc=%0b ovf=%0b",
                     dut, e.name, $time, v, t, o, e.value, e.tc, e.ovf);
        end
    endtask

    // Monitors: one expectation per clock edge while an entry is pending.
    always @(posedge clk) begin
        #1;
        if (q_a.size() != 0) compare("a", q_a.pop_front(), a_value, a_tc, a_ovf);
    end

    always @(posedge clk) begin
        #1;
        if (q_b.size() != 0) compare("b", q_b.pop_front(), b_value, b_tc, b_ovf);
    end

    task automatic cyc_a(input logic rst, input logic en, input logic up, input logic sat,
                         input logic ld, input logic [7:0] lv, input logic clr,
                         input logic [7:0] ev, input logic etc, input logic eovf,
                         input string name);
        exp_t e;
        a_reset = rst; a_en = en; a_up = up; a_sat = sat;
        a_load = ld; a_lv = lv; a_clr = clr;
        e.value = ev; e.tc = etc; e.ovf = eovf; e.name = name;
        q_a.push_back(e);
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic rst, input logic en,
                         input logic [7:0] ev, input string name);
        exp_t e;
        b_reset = rst; b_en = en;
        e.value = ev; e.tc = 1'b0; e.ovf = 1'b0; e.name = name;
        q_b.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Reset held two cycles with en=1
        cyc_a(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "reset0");
        cyc_a(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "reset1");

        // Up, wrap: 1..9 then 0 with tc and ovf
        for (int i = 1; i <= 9; i++)
            cyc_a(0, 1, 1, 0, 0, 0, 0, 8'(i), 0, 0, "up_wrap");
        cyc_a(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, "wrap_9_to_0");
        cyc_a(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "tc_one_cycle");

        // Clear ovf, then load 2 and count down saturating
        cyc_a(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "clr_ovf");
        cyc_a(0, 0, 0, 1, 1, 2, 0, 2, 0, 0, "load2");
        cyc_a(0, 1, 0, 1, 0, 0, 0, 1, 0, 0, "down_sat1");
        cyc_a(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, "down_sat2");
        cyc_a(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, "down_sat3");
        cyc_a(0, 1, 0, 1, 0, 0, 0, 0, 1, 1, "down_sat4");
        cyc_a(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, "sat_idle");

        // Load clamp with en=1: no step on the load cycle
        cyc_a(0, 1, 1, 0, 1, 200, 0, 9, 0, 1, "load200_clamp");
        cyc_a(0, 0, 1, 0, 0, 0, 0, 9, 0, 1, "hold_after_load");
        cyc_a(0, 0, 1, 0, 1, 10, 0, 9, 0, 1, "load10_clamp");
        cyc_a(0, 0, 1, 0, 1, 9, 0, 9, 0, 1, "load9_exact");
        cyc_a(1, 1, 1, 0, 1, 200, 0, 0, 0, 0, "load_and_reset");

        // Sticky ovf: set wins over same-cycle clear
        cyc_a(0, 0, 1, 0, 1, 9, 0, 9, 0, 0, "load9");
        cyc_a(0, 1, 1, 0, 0, 0, 1, 0, 1, 1, "wrap_with_clr");
        cyc_a(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "clr_after_wrap");

        // Direction change, down wrap, up saturate
        cyc_a(0, 0, 1, 0, 1, 5, 0, 5, 0, 0, "load5");
        cyc_a(0, 1, 1, 0, 0, 0, 0, 6, 0, 0, "up_to6");
        cyc_a(0, 1, 0, 0, 0, 0, 0, 5, 0, 0, "dir_change_to5");
        cyc_a(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "load0");
        cyc_a(0, 1, 0, 0, 0, 0, 0, 9, 1, 1, "down_wrap_0_to_9");
        cyc_a(0, 1, 1, 1, 0, 0, 0, 9, 1, 1, "up_sat_at9");
        cyc_a(0, 1, 1, 0, 0, 0, 0, 0, 1, 1, "up_wrap_again");
        cyc_a(0, 1, 1, 0, 0, 0, 0, 1, 0, 1, "after_wrap");

        // Mid-count reset returns to reset state
        cyc_a(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "reset_mid");
        cyc_a(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, "resume");
        a_en = 1'b0;

        // Prescaler instance: ticks on every 4th enabled edge
        cyc_b(1, 0, 0, "b_reset");
        for (int k = 1; k <= 12; k++)
            cyc_b(0, 1, 8'(k / 4), "b_prescale");
        cyc_b(0, 1, 3, "b_c13");
        cyc_b(0, 1, 3, "b_c14");
        cyc_b(0, 0, 3, "b_pause1");
        cyc_b(0, 0, 3, "b_pause2");
        cyc_b(0, 1, 3, "b_c17");
        cyc_b(0, 1, 4, "b_delayed_tick");
        cyc_b(0, 1, 4, "b_c19");
        cyc_b(1, 1, 0, "b_reset_mid_prescale");
        cyc_b(0, 1, 0, "b_r1");
        cyc_b(0, 1, 0, "b_r2");
        cyc_b(0, 1, 0, "b_r3");
        cyc_b(0, 1, 1, "b_r4_tick");
        b_en = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: pending a=%0d b=%0d, expected 0 0", q_a.size(), q_b.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
